// File: rtl/lab62soc_accum_ctrl.sv
// lab62soc_accum_ctrl: Avalon-MM slave for the lab 6.2 active-low ACCUMULATE key.
// The raw key is synchronised, optionally debounced, and every press is latched
// in an edge-capture register (maskable irq) and counted in a wrapping counter.
// Build option ACCUM_DEBOUNCE_EN: when defined, a debounce FSM filters the
// synchronised key; when undefined, the synchronised key is used directly and
// every falling edge counts as a press.
module lab62soc_accum_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable;
  logic             pressEvent;
  logic             wrEn;
  logic             mask_q, mask_d;
  logic             edgecap_q, edgecap_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      readMux;
  logic [31:0]      readdata_q, readdata_d;
  logic             unusedBits;

  // Only bit 0 of the write bus carries meaning for every register.
  assign unusedBits = &{1'b0, writedata[31:1], DEBOUNCE_CYCLES[0]};

  // Two-flop synchroniser for the asynchronous key; idles high (released).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef ACCUM_DEBOUNCE_EN
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } debounceStateT;

  debounceStateT     state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  // Debounce state and down-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELEASED;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // A level change is accepted only after it has been seen for the full interval.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      RELEASED: begin
        if (!sync2_q) begin
          state_d = PRESS_PEND;
          dcnt_d  = DCNT_LOAD;
        end
      end
      PRESS_PEND: begin
        if (sync2_q) begin
          state_d = RELEASED;
        end else if (dcnt_q == DCNT_ONE) begin
          state_d = PRESSED;
        end else begin
          dcnt_d = dcnt_q - DCNT_ONE;
        end
      end
      PRESSED: begin
        if (sync2_q) begin
          state_d = RELEASE_PEND;
          dcnt_d  = DCNT_LOAD;
        end
      end
      RELEASE_PEND: begin
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (dcnt_q == DCNT_ONE) begin
          state_d = RELEASED;
        end else begin
          dcnt_d = dcnt_q - DCNT_ONE;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // A press is the debounced level falling; a bounce back from RELEASE_PEND is not one.
  always_comb begin
    stable     = (state_q == RELEASED) || (state_q == PRESS_PEND);
    pressEvent = (state_q == PRESS_PEND) && (state_d == PRESSED);
  end
`else
  logic stablePrev_q;

  // Remembers the previous synchronised level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      stablePrev_q <= 1'b1;
    end else begin
      stablePrev_q <= sync2_q;
    end
  end

  // Without debouncing, every falling edge of the synchronised key is a press.
  always_comb begin
    stable     = sync2_q;
    pressEvent = stablePrev_q & ~sync2_q;
  end
`endif

  assign wrEn = chipselect & ~write_n;

  // Register updates: bus writes first, then a press overrides (set and count win).
  always_comb begin
    mask_d    = mask_q;
    edgecap_d = edgecap_q;
    count_d   = count_q;
    if (wrEn) begin
      case (address)
        2'd1: mask_d = writedata[0];
        2'd2: if (writedata[0]) edgecap_d = 1'b0;
        2'd3: count_d = '0;
        default: ;
      endcase
    end
    if (pressEvent) begin
      edgecap_d = 1'b1;
      count_d   = count_d + CNT_W'(1);
    end
  end

  // Read mux; reads have no side effects and idle cycles return zero.
  always_comb begin
    readMux = '0;
    case (address)
      2'd0: readMux[0] = stable;
      2'd1: readMux[0] = mask_q;
      2'd2: readMux[0] = edgecap_q;
      2'd3: readMux[CNT_W-1:0] = count_q;
      default: ;
    endcase
    readdata_d = chipselect ? readMux : 32'd0;
  end

  // Software-visible registers and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= 1'b0;
      edgecap_q  <= 1'b0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = edgecap_q & mask_q;

endmodule

// File: doc/lab62soc_accum_ctrl.md
# lab62soc_accum_ctrl

Avalon-MM slave controller for the lab 6.2 SoC's active-low ACCUMULATE push-button. It synchronises and debounces the raw key, detects press events and latches them in an edge-capture register with a maskable interrupt to the NIOS II. It also keeps a press counter, so software can service the key by polling or by interrupt without missing presses.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- CNT_W, 16: width of the press counter; must be ≤ 32.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  1  raw key, asynchronous; 0 = pressed.
- irq  out  1  interrupt request, active-high, level.

## Operation
- Register map. Unused bits read 0 and ignore writes.
  - 0 DATA (RO): bit0 = debounced key level.
  - 1 IRQMASK (RW): bit0.
  - 2 EDGECAP (W1C): bit0 = press latched. Writing bit0=1 clears it.
  - 3 COUNT (RW): bits[CNT_W-1:0] = press count. Any write clears it to 0.
- Synchroniser: two flops, sync1 then sync2. Both reset to 1.
- Debounce FSM, clocked on sync2. A down-counter `dcnt` ranges over 0..DEBOUNCE_CYCLES-1.
  - RELEASED: stable=1. If sync2=0, go to PRESS_PEND and load dcnt=DEBOUNCE_CYCLES-1.
  - PRESS_PEND: stable=1. If sync2=1, return to RELEASED. Otherwise, when dcnt=1, go to PRESSED. Otherwise decrement dcnt.
  - PRESSED: stable=0. If sync2=1, go to RELEASE_PEND and load dcnt.
  - RELEASE_PEND: stable=0. If sync2=0, return to PRESSED. Otherwise, when dcnt=1, go to RELEASED. Otherwise decrement dcnt.
- Press event: a one-cycle pulse on the cycle the FSM enters PRESSED. Release events are not captured.
- A press event sets EDGECAP.
  - If a W1C write to EDGECAP lands in the same cycle as a press, EDGECAP stays set (set wins).
- A press event increments COUNT, wrapping modulo 2^CNT_W. It does not saturate.
  - If a COUNT write lands in the same cycle as a press, COUNT becomes 1 (the clear applies first, then the increment).
- irq = EDGECAP & IRQMASK, combinational from registers. No extra latency.
- Reads have no side effects.
- Reset values:
  - Registers: EDGECAP=0, IRQMASK=0, COUNT=0, readdata=0, irq=0.
  - FSM: state=RELEASED, dcnt=0, stable=1.

## Timing
- Registers update at the clock edge where chipselect=1 and write_n=0.
- Read latency is 1. readdata is loaded every cycle from the mux at the current address, so readdata at edge n+1 reflects address and register contents at edge n.
  - While chipselect=0, readdata loads 0.
- Press latency: in_port falls before edge 0 and then stays low.
  - sync2=0 after edge 2.
  - The FSM enters PRESSED (stable=0) after edge 2+DEBOUNCE_CYCLES.
  - EDGECAP=1, COUNT increment and irq (if masked in) occur after that same edge.
- A glitch shorter than DEBOUNCE_CYCLES cycles, as seen on sync2, produces no event.
- Reset asserted mid-debounce returns the FSM to RELEASED on the next edge and aborts any pending press.
  - If the key is still held after reset deasserts, one press is detected after a full new debounce interval.

## Configuration
- ACCUM_DEBOUNCE_EN defined: the debounce FSM and dcnt are built as described above.
- ACCUM_DEBOUNCE_EN undefined:
  - stable = sync2 directly, and the press event is the falling edge of sync2 (1 to 0).
  - Press latency becomes 3 edges, measured from in_port falling to EDGECAP set.
  - DEBOUNCE_CYCLES is ignored, and no debounce counter logic is synthesised.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=16 and ACCUM_DEBOUNCE_EN defined, unless noted.

- Reset, then read addresses 0, 1, 2 and 3 → readdata = 1, 0, 0, 0; irq=0.
- Glitch rejection: hold in_port=0 for 3 cycles, then 1 → DATA stays 1, EDGECAP=0, COUNT=0.
- Clean press: write IRQMASK=1, then hold in_port low for 10 cycles → after edge 6, EDGECAP=1, irq=1 and COUNT=1. Then:
  - W1C 0x1 to address 2 → EDGECAP=0 and irq=0 on the next cycle.
  - Release and press again → COUNT=2.
- Collision: time a W1C to EDGECAP and a COUNT write onto the press-event cycle → EDGECAP=1 and COUNT=1.
- Wrap and reset mid-operation:
  - Preload by pressing 65536 times with CNT_W=16 → COUNT reads 0.
  - Assert reset during PRESS_PEND → no event afterwards while the key stays released.
- Macro undefined: in_port falls before edge 0 → EDGECAP=1 after edge 3. A 1-cycle glitch is captured as a press.
